mem_word_responder: RTL and testbench
=====================================

Name: mem_word_responder

Overview:
- Memory-side responder for the control unit's word-access handshake.
- Accepts 16-bit word read/write requests (MAR address, MBR data) and serves each one as two sequential byte accesses to an internal byte-wide array.
- Little-endian: low byte at addr, high byte at addr+1.
- Replaces direct array access: the control FSM raises req and waits for the one-cycle ack.

Parameters:
- ADDR_BITS, 14, byte-address width actually decoded; array depth = 2**ADDR_BITS bytes (16384).
- WAIT_STATES, 0, extra idle cycles inserted before each byte access (0..7).

Ports:
- clock  input  1  system clock, rising-edge active
- reset  input  1  synchronous, active-high reset
- req  input  1  request; initiator holds high until it samples ack
- we  input  1  1 = write, 0 = read; sampled at accept
- addr  input  16  byte address of the word; bits above ADDR_BITS-1 ignored
- wdata  input  16  write data; sampled at accept
- rdata  output  16  read data; valid while ack=1 and held until the next read completes
- ack  output  1  one-cycle completion pulse
- busy  output  1  high from accept edge until the edge that clears ack
- err  output  1  alignment error flag, qualified by ack (see Optional Feature)

Behaviour:
- Reset (synchronous, when reset=1 at a rising edge):
  - state=IDLE; rdata=0, ack=0, busy=0, err=0; wait counter=0.
  - Array contents are not cleared.
  - Reset has priority over every other event.
- FSM states: IDLE, LO, HI, DONE.
- IDLE:
  - If req=1 at an edge (accept edge E0): latch we, addr[ADDR_BITS-1:0] and wdata; busy<=1; go to LO.
  - Otherwise stay in IDLE.
- LO: count WAIT_STATES cycles, then on the next edge access byte a = latched addr:
  - write: mem[a] <= wdata[7:0].
  - read: rdata_lo captured into an internal holding register.
  - Go to HI.
- HI: count WAIT_STATES cycles, then on the next edge access byte b = (a+1) mod 2**ADDR_BITS; 16383 wraps to 0.
  - write: mem[b] <= wdata[15:8].
  - read: rdata <= {mem[b], rdata_lo}.
  - On the same edge: ack<=1; go to DONE.
- DONE: next edge sets ack<=0, busy<=0; go to IDLE. req is ignored in DONE.
- Latency: ack rises on edge E0 + 2*(1+WAIT_STATES), i.e. E0+2 for WAIT_STATES=0; ack is high for exactly one cycle.
- Back-to-back: if req is still high in IDLE after ack, it is a new request. The initiator must drop req on the cycle it sees ack. Minimum spacing between accepts is 2*(1+WAIT_STATES)+2 cycles.
- req, we, addr and wdata changing while busy=1: ignored; the latched values govern. Requests during busy are not queued.
- Write transactions leave rdata unchanged.
- Reset mid-operation aborts immediately.
  - A write aborted after the LO access leaves the low byte written and the high byte old. This is documented and acceptable.
  - ack is never produced for an aborted transaction.
- Array: reg [7:0] x 2**ADDR_BITS, one byte access per cycle, no simultaneous dual-port use.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: an accepted request with addr[0]=1 performs no array access and skips LO/HI.
  - Next edge (E0+1): ack<=1, err<=1; go to DONE.
  - rdata is unchanged.
  - err clears with ack.
  - Even addresses behave as above with err=0.
- Undefined: odd addresses are served normally; the second byte is addr+1 with wrap; err is tied 0.

Test Plan:
- Reset, then read addr 0x0000 with zeroed preload (WAIT_STATES=0) -> ack at E0+2 for 1 cycle, rdata=0x0000, busy high E0..E0+3.
- Write 0xBEEF @0x0010, then read @0x0010 -> mem[0x10]=0xEF, mem[0x11]=0xBE, rdata=0xBEEF; read @0x0011 (macro off) -> rdata[7:0]=0xBE.
- Write 0x1234 @0x3FFF (macro off) -> mem[0x3FFF]=0x34, mem[0x0000]=0x12; read @0x3FFF returns 0x1234; addr 0xFFFF aliases 0x3FFF.
- WAIT_STATES=3: read -> ack exactly at E0+8; toggling addr/wdata while busy has no effect; req held high through ack starts a 2nd transaction on the edge after DONE.
- Reset asserted the cycle after the LO write of 0xAAAA over 0x5555 @0x0020 -> no ack, busy=0, mem[0x20]=0xAA, mem[0x21]=0x55.
- MEM_ALIGN_CHECK_EN defined, write @0x0021 -> ack and err high at E0+1, memory unchanged; the following even-address read returns err=0.

Source files
------------

// File: rtl/mem_word_responder.sv
// Word-access responder: each 16-bit request becomes two little-endian byte accesses to a byte array.
// Optional feature macro MEM_ALIGN_CHECK_EN: odd word addresses are rejected with ack+err and no access.
module mem_word_responder #(
   parameter int unsigned ADDR_BITS   = 14,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req,
   input  logic        we,
   input  logic [15:0] addr,
   input  logic [15:0] wdata,
   output logic [15:0] rdata,
   output logic        ack,
   output logic        busy,
   output logic        err
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_LO   = 2'd1;
   localparam logic [1:0] ST_HI   = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   localparam int unsigned DEPTH     = 1 << ADDR_BITS;
   localparam logic [2:0]  WAIT_LAST = 3'(WAIT_STATES);

   logic [1:0]           r_state;
   logic [2:0]           r_wait;
   logic                 r_we;
   logic [ADDR_BITS-1:0] r_addr;
   logic [15:0]          r_wdata;
   logic [7:0]           r_rdata_lo;
   logic [15:0]          r_rdata;
   logic                 r_ack;
   logic                 r_busy;
   logic                 r_err;
   logic [7:0]           r_mem [DEPTH];

   logic                 w_accept;
   logic                 w_wait_done;
   logic                 w_odd_reject;
   logic                 w_lo_access;
   logic                 w_hi_access;
   logic [ADDR_BITS-1:0] w_mem_addr;
   logic [7:0]           w_mem_rd;
   logic [7:0]           w_mem_wd;
   logic                 w_mem_we;

   assign w_accept    = (r_state == ST_IDLE) && req;
   assign w_wait_done = (r_wait == WAIT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
   // Rejection is decided on the first edge after accept, ahead of any wait states.
   assign w_odd_reject = (r_state == ST_LO) && r_addr[0];
`else
   assign w_odd_reject = 1'b0;
`endif

   assign w_lo_access = (r_state == ST_LO) && w_wait_done && !w_odd_reject;
   assign w_hi_access = (r_state == ST_HI) && w_wait_done;

   // The high byte address wraps naturally at the decoded width.
   assign w_mem_addr = w_hi_access ? (r_addr + ADDR_BITS'(1)) : r_addr;
   assign w_mem_wd   = w_hi_access ? r_wdata[15:8] : r_wdata[7:0];
   assign w_mem_we   = r_we && (w_lo_access || w_hi_access);
   assign w_mem_rd   = r_mem[w_mem_addr];

   always_ff @(posedge clock) begin
      if (w_mem_we && !reset) begin
         r_mem[w_mem_addr] <= w_mem_wd;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset && w_accept) begin
         r_we    <= we;
         r_addr  <= addr[ADDR_BITS-1:0];
         r_wdata <= wdata;
      end
      if (!reset && w_lo_access && !r_we) begin
         r_rdata_lo <= w_mem_rd;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_wait  <= '0;
         r_rdata <= '0;
         r_ack   <= 1'b0;
         r_busy  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_busy  <= 1'b1;
                  r_wait  <= '0;
                  r_state <= ST_LO;
               end
            end
            ST_LO: begin
               if (w_odd_reject) begin
                  r_ack   <= 1'b1;
                  r_err   <= 1'b1;
                  r_state <= ST_DONE;
               end else if (!w_wait_done) begin
                  r_wait <= r_wait + 3'd1;
               end else begin
                  r_wait  <= '0;
                  r_state <= ST_HI;
               end
            end
            ST_HI: begin
               if (!w_wait_done) begin
                  r_wait <= r_wait + 3'd1;
               end else begin
                  if (!r_we) begin
                     r_rdata <= {w_mem_rd, r_rdata_lo};
                  end
                  r_ack   <= 1'b1;
                  r_wait  <= '0;
                  r_state <= ST_DONE;
               end
            end
            ST_DONE: begin
               r_ack   <= 1'b0;
               r_busy  <= 1'b0;
               r_err   <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   if (ADDR_BITS < 16) begin : g_unused_addr
      logic w_unused_hi;
      assign w_unused_hi = ^addr[15:ADDR_BITS];
   end

   assign rdata = r_rdata;
   assign ack   = r_ack;
   assign busy  = r_busy;
   assign err   = r_err;

endmodule

// File: tb/tb_mem_word_responder.sv
// Bench for mem_word_responder: two instances (0 and 3 wait states) share stimulus and are
// checked every cycle against a transaction-level model, plus hand-computed directed expectations.
module tb_mem_word_responder;

   localparam int unsigned WS0   = 0;
   localparam int unsigned WS1   = 3;
   localparam int unsigned DEPTH = 16384;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req   = 1'b0;
   logic        we    = 1'b0;
   logic [15:0] addr  = '0;
   logic [15:0] wdata = '0;

   logic [15:0] rdata0, rdata1;
   logic        ack0, ack1, busy0, busy1, err0, err1;

   int checks   = 0;
   int failures = 0;

   initial forever #5 clock = ~clock;

   mem_word_responder #(.ADDR_BITS(14), .WAIT_STATES(WS0)) u_dut0 (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
   );

   mem_word_responder #(.ADDR_BITS(14), .WAIT_STATES(WS1)) u_dut1 (
      .clock(clock), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .rdata(rdata1), .ack(ack1), .busy(busy1), .err(err1)
   );

   // Transaction-level model: each instance has a latency L; low byte happens at L/2, high byte at L.
   logic [7:0]  m_mem   [2][DEPTH];
   bit          m_known [2][DEPTH];
   bit          m_busy [2], m_ack [2], m_err [2], m_we [2], m_odd [2], m_lok [2];
   int unsigned m_cnt [2], m_a [2];
   logic [15:0] m_wd [2], m_rd [2], m_rdmask [2];
   logic [7:0]  m_lo [2];
   bit          m_valid = 1'b0;

   task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp,
                      input logic [15:0] mask);
      checks++;
      if (((got ^ exp) & mask) !== 16'h0000) begin
         failures++;
         $display("FAIL %s got=%h exp=%h mask=%h t=%0t", nm, got, exp, mask, $time);
      end
   endtask

   task automatic model_step(input int k, input bit rst, input bit rq, input bit w,
                             input logic [15:0] ad, input logic [15:0] wd);
      int unsigned lat, b;
      lat = 2 * (1 + ((k == 0) ? WS0 : WS1));
      if (rst) begin
         m_busy[k] = 0; m_ack[k] = 0; m_err[k] = 0; m_cnt[k] = 0;
         m_rd[k] = '0; m_rdmask[k] = 16'hFFFF;
      end else if (m_ack[k]) begin
         m_ack[k] = 0; m_err[k] = 0; m_busy[k] = 0;
      end else if (m_busy[k]) begin
         m_cnt[k]++;
         if (m_odd[k]) begin
            m_ack[k] = 1; m_err[k] = 1;
         end else begin
            if (m_cnt[k] == lat / 2) begin
               if (m_we[k]) begin
                  m_mem[k][m_a[k]] = m_wd[k][7:0];
                  m_known[k][m_a[k]] = 1;
               end else begin
                  m_lo[k]  = m_mem[k][m_a[k]];
                  m_lok[k] = m_known[k][m_a[k]];
               end
            end
            if (m_cnt[k] == lat) begin
               b = (m_a[k] + 1) % DEPTH;
               if (m_we[k]) begin
                  m_mem[k][b] = m_wd[k][15:8];
                  m_known[k][b] = 1;
               end else begin
                  m_rd[k]     = {m_mem[k][b], m_lo[k]};
                  m_rdmask[k] = {{8{m_known[k][b]}}, {8{m_lok[k]}}};
               end
               m_ack[k] = 1;
            end
         end
      end else if (rq) begin
         m_busy[k] = 1; m_cnt[k] = 0; m_we[k] = w;
         m_a[k] = ad % DEPTH; m_wd[k] = wd; m_odd[k] = 0;
`ifdef MEM_ALIGN_CHECK_EN
         m_odd[k] = ad[0];
`endif
      end
   endtask

   initial forever begin
      @(posedge clock);
      for (int k = 0; k < 2; k++) model_step(k, reset, req, we, addr, wdata);
      if (reset) m_valid = 1'b1;
   end

   initial forever begin
      @(negedge clock);
      if (m_valid) begin
         chk("ack0",   {15'h0, ack0},  {15'h0, m_ack[0]},  16'hFFFF);
         chk("busy0",  {15'h0, busy0}, {15'h0, m_busy[0]}, 16'hFFFF);
         chk("err0",   {15'h0, err0},  {15'h0, m_err[0]},  16'hFFFF);
         chk("rdata0", rdata0, m_rd[0], m_rdmask[0]);
         chk("ack1",   {15'h0, ack1},  {15'h0, m_ack[1]},  16'hFFFF);
         chk("busy1",  {15'h0, busy1}, {15'h0, m_busy[1]}, 16'hFFFF);
         chk("err1",   {15'h0, err1},  {15'h0, m_err[1]},  16'hFFFF);
         chk("rdata1", rdata1, m_rd[1], m_rdmask[1]);
      end
   end

   task automatic wait_idle();
      bit done;
      done = 0;
      for (int i = 0; i < 50 && !done; i++) begin
         if (!busy0 && !busy1) done = 1;
         else begin
            @(posedge clock); #1;
         end
      end
      if (!done) chk("idle_timeout", {14'h0, busy1, busy0}, 16'h0000, 16'hFFFF);
   endtask

   // Called at posedge+1; the next edge is the accept edge E0. Latencies counted in edges after E0.
   task automatic tx(input bit w, input logic [15:0] a, input logic [15:0] d, input bit scramble,
                     output int lat0, output int lat1, output logic [15:0] rd0, output bit e0);
      lat0 = -1; lat1 = -1; rd0 = '0; e0 = 0;
      wait_idle();
      req = 1; we = w; addr = a; wdata = d;
      @(posedge clock); #1;
      for (int n = 1; n <= 40 && (lat0 < 0 || lat1 < 0); n++) begin
         if (scramble) begin
            we = 1'($urandom); addr = 16'($urandom); wdata = 16'($urandom);
         end
         @(posedge clock); #1;
         if (ack0 && lat0 < 0) begin
            lat0 = n; rd0 = rdata0; e0 = err0; req = 0;
         end
         if (ack1 && lat1 < 0) lat1 = n;
      end
      if (lat0 < 0 || lat1 < 0) chk("ack_timeout", 16'(lat0 < 0), 16'h0000, 16'hFFFF);
      req = 0; we = 0;
      wait_idle();
   endtask

   function automatic logic [15:0] rand_addr();
      logic [13:0] lo;
      logic [1:0]  hi;
      if ($urandom_range(0, 1) == 1) lo = 14'($urandom_range(0, 63));
      else                           lo = 14'(32'h3FC0 + $urandom_range(0, 63));
      hi = 2'($urandom_range(0, 3));
      return {hi, lo};
   endfunction

   int          l0, l1, n0, n1;
   logic [15:0] rd;
   bit          e;

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_rdata", rdata0, 16'h0000, 16'hFFFF);
      chk("rst_ack",   {15'h0, ack0},  16'h0000, 16'hFFFF);
      chk("rst_busy",  {15'h0, busy0}, 16'h0000, 16'hFFFF);
      chk("rst_err",   {15'h0, err0},  16'h0000, 16'hFFFF);
      reset = 0;

      for (int i = 0; i < 32; i++) begin
         tx(1, 16'(2 * i), 16'($urandom), 0, l0, l1, rd, e);
         tx(1, 16'(32'h3FC0 + 2 * i), 16'($urandom), 0, l0, l1, rd, e);
      end

      tx(1, 16'h0000, 16'h0000, 0, l0, l1, rd, e);
      tx(0, 16'h0000, 16'h0000, 0, l0, l1, rd, e);
      chk("rd0_lat_ws0", 16'(l0), 16'd2, 16'hFFFF);
      chk("rd0_lat_ws3", 16'(l1), 16'd8, 16'hFFFF);
      chk("rd0_data",    rd, 16'h0000, 16'hFFFF);

      tx(1, 16'h0010, 16'hBEEF, 0, l0, l1, rd, e);
      tx(0, 16'h0010, 16'h0000, 0, l0, l1, rd, e);
      chk("rd10_data", rd, 16'hBEEF, 16'hFFFF);
      chk("rd10_err",  {15'h0, e}, 16'h0000, 16'hFFFF);

`ifndef MEM_ALIGN_CHECK_EN
      tx(0, 16'h0011, 16'h0000, 0, l0, l1, rd, e);
      chk("rd11_lo", rd, 16'h00BE, 16'h00FF);

      tx(1, 16'h3FFF, 16'h1234, 0, l0, l1, rd, e);
      tx(0, 16'h3FFF, 16'h0000, 0, l0, l1, rd, e);
      chk("rd3fff_wrap", rd, 16'h1234, 16'hFFFF);
      tx(0, 16'h0000, 16'h0000, 0, l0, l1, rd, e);
      chk("rd0_after_wrap", rd, 16'h0012, 16'hFFFF);
      tx(0, 16'hFFFF, 16'h0000, 0, l0, l1, rd, e);
      chk("rdffff_alias", rd, 16'h1234, 16'hFFFF);
`endif

      tx(0, 16'h0010, 16'h0000, 1, l0, l1, rd, e);
      chk("scramble_data0", rd, 16'hBEEF, 16'hFFFF);
      chk("scramble_lat1",  16'(l1), 16'd8, 16'hFFFF);
      chk("scramble_data1", rdata1, 16'hBEEF, 16'hFFFF);

      wait_idle();
      req = 1; we = 0; addr = 16'h0010; n0 = 0; n1 = 0;
      for (int i = 0; i <= 20; i++) begin
         @(posedge clock); #1;
         if (ack0) n0++;
         if (ack1) n1++;
         if (i == 11) req = 0;
      end
      chk("b2b_acks_ws0", 16'(n0), 16'd3, 16'hFFFF);
      chk("b2b_acks_ws3", 16'(n1), 16'd2, 16'hFFFF);

      tx(1, 16'h0020, 16'h5555, 0, l0, l1, rd, e);
      wait_idle();
      req = 1; we = 1; addr = 16'h0020; wdata = 16'hAAAA;
      @(posedge clock); #1;
      req = 0;
      @(posedge clock); #1;
      reset = 1;
      @(posedge clock); #1;
      chk("abort_ack0",  {15'h0, ack0},  16'h0000, 16'hFFFF);
      chk("abort_busy0", {15'h0, busy0}, 16'h0000, 16'hFFFF);
      chk("abort_busy1", {15'h0, busy1}, 16'h0000, 16'hFFFF);
      reset = 0;
      tx(0, 16'h0020, 16'h0000, 0, l0, l1, rd, e);
      chk("abort_mem", rd, 16'h55AA, 16'hFFFF);

`ifdef MEM_ALIGN_CHECK_EN
      tx(1, 16'h0021, 16'h7777, 0, l0, l1, rd, e);
      chk("odd_lat_ws0", 16'(l0), 16'd1, 16'hFFFF);
      chk("odd_lat_ws3", 16'(l1), 16'd1, 16'hFFFF);
      chk("odd_err",     {15'h0, e}, 16'h0001, 16'hFFFF);
      chk("odd_rdata",   rd, 16'h55AA, 16'hFFFF);
      tx(0, 16'h0020, 16'h0000, 0, l0, l1, rd, e);
      chk("even_err",  {15'h0, e}, 16'h0000, 16'hFFFF);
      chk("even_data", rd, 16'h55AA, 16'hFFFF);
`endif

      for (int c = 0; c < 3000; c++) begin
         reset = ($urandom_range(0, 299) == 0);
         req   = ($urandom_range(0, 2) != 0);
         we    = 1'($urandom);
         addr  = rand_addr();
         wdata = 16'($urandom);
         @(posedge clock); #1;
      end
      reset = 0; req = 0; we = 0;
      wait_idle();
      repeat (2) @(posedge clock);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
